// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Brief    : Two-phase fetch/execute sequencer and program counter for the
//            nibble processor. Supports increment, absolute jump and halt.
//            The optional return-address stack is built when the macro
//            CALL_STACK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer #(
  parameter int ADDR_W      = 12,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,      // synchronous, active-low
  input  logic              enable_i,
  input  logic              inc_en_i,
  input  logic              load_en_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic              halt_req_i,
  input  logic              call_en_i,
  input  logic              ret_en_i,
  output logic [ADDR_W-1:0] pc_addr_o,
  output logic              phase_o,
  output logic              halted_o,
  output logic              wrapped_o,
  output logic              stack_err_o
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              wrapped_q, wrapped_d;

  // Increment with carry-out; the carry marks a wrap past all-ones.
  logic [ADDR_W:0]   pc_sum;
  logic [ADDR_W-1:0] pc_inc;
  logic              pc_carry;

  assign pc_sum   = {1'b0, pc_q} + (ADDR_W+1)'(1);
  assign pc_inc   = pc_sum[ADDR_W-1:0];
  assign pc_carry = pc_sum[ADDR_W];

`ifdef CALL_STACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [SP_W-1:0]   sp_q, sp_d, sp_dec;
  logic              err_q, err_d;
  logic              push_en;

  assign sp_dec = sp_q - SP_W'(1);
`else
  // Call/return controls have no effect without the stack.
  logic unused_stack_inputs;
  assign unused_stack_inputs = ^{call_en_i, ret_en_i};
`endif

  // Next-state and PC update; every register holds unless enable is high.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    wrapped_d = wrapped_q;
`ifdef CALL_STACK_EN
    sp_d      = sp_q;
    err_d     = err_q;
    push_en   = 1'b0;
`endif
    if (enable_i) begin
      unique case (state_q)
        S_FETCH: state_d = S_EXEC;
        S_EXEC: begin
          if (halt_req_i) begin
            state_d = S_HALT;
          end else begin
            state_d = S_FETCH;
`ifdef CALL_STACK_EN
            if (ret_en_i) begin
              if (sp_q == '0) begin
                // Underflow: skip past the return instead of popping.
                pc_d      = pc_inc;
                wrapped_d = wrapped_q | pc_carry;
                err_d     = 1'b1;
              end else begin
                pc_d = stack_q[sp_dec[IDX_W-1:0]];
                sp_d = sp_dec;
              end
            end else if (call_en_i) begin
              if (sp_q == SP_W'(STACK_DEPTH)) begin
                // Overflow: the call is dropped and execution falls through.
                pc_d      = pc_inc;
                wrapped_d = wrapped_q | pc_carry;
                err_d     = 1'b1;
              end else begin
                push_en = 1'b1;
                pc_d    = load_addr_i;
                sp_d    = sp_q + SP_W'(1);
              end
            end else
`endif
            if (load_en_i) begin
              pc_d = load_addr_i;
            end else if (inc_en_i) begin
              pc_d      = pc_inc;
              wrapped_d = wrapped_q | pc_carry;
            end
          end
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_FETCH;
      endcase
    end
  end

  // Architectural state registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      wrapped_q <= 1'b0;
`ifdef CALL_STACK_EN
      sp_q      <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      wrapped_q <= wrapped_d;
`ifdef CALL_STACK_EN
      sp_q      <= sp_d;
      err_q     <= err_d;
`endif
    end
  end

`ifdef CALL_STACK_EN
  // Return-address storage; contents are deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (reset_i && push_en) begin
      stack_q[sp_q[IDX_W-1:0]] <= pc_inc;
    end
  end

  assign stack_err_o = err_q;
`else
  assign stack_err_o = 1'b0;
`endif

  assign pc_addr_o = pc_q;
  assign phase_o   = (state_q == S_EXEC);
  assign halted_o  = (state_q == S_HALT);
  assign wrapped_o = wrapped_q;

endmodule

`default_nettype wire
